// File: rtl/multi_edge_detector_if.sv
// Signal bundle between raw status/button lines, the register fabric and multi_edge_detector.
// master = the side that drives raw inputs, mode and clear; slave = the detector itself.
interface multi_edge_detector_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]       signal_in;
  logic [2*N_CH-1:0]     mode;
  logic [N_CH-1:0]       clear;
  logic [N_CH-1:0]       level_out;
  logic [N_CH-1:0]       edge_out;
  logic [N_CH-1:0]       sticky_out;
  logic [N_CH*CNT_W-1:0] edge_count;
  logic                  irq;

  modport master (
    output signal_in, mode, clear,
    input  level_out, edge_out, sticky_out, edge_count, irq
  );

  modport slave (
    input  signal_in, mode, clear,
    output level_out, edge_out, sticky_out, edge_count, irq
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel synchronise + glitch-filter + edge detector with per-channel pulse,
// sticky flag, saturating event counter and a shared interrupt.
module multi_edge_detector #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_edge_detector_if.slave  bus
);
  localparam int             FCW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_LEN - 1);

  logic [N_CH-1:0]       level_v;
  logic [N_CH-1:0]       edge_v;
  logic [N_CH-1:0]       sticky_v;
  logic [N_CH*CNT_W-1:0] count_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic [FCW-1:0]         fcnt;
    logic                   filt;
    logic                   toggle;
    logic                   qual;
    logic                   edge_r;
    logic                   sticky_r;
    logic [CNT_W-1:0]       cnt;

    assign sync_q = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_r <= '0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], bus.signal_in[i]};
      end
    end

    // filt flips on the FILTER_LEN-th consecutive mismatch; the edge type is the old filt value.
    always_comb begin
      toggle = (sync_q != filt) && (fcnt == F_LAST);
      qual   = toggle & (filt ? bus.mode[2*i+1] : bus.mode[2*i]);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        fcnt <= '0;
        filt <= 1'b0;
      end else if (toggle) begin
        fcnt <= '0;
        filt <= ~filt;
      end else if (sync_q == filt) begin
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FCW'(1);
      end
    end

    // A qualified edge beats a simultaneous clear for both the flag and the counter.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        edge_r   <= 1'b0;
        sticky_r <= 1'b0;
        cnt      <= '0;
      end else begin
        edge_r <= qual;
        if (qual) begin
          sticky_r <= 1'b1;
        end else if (bus.clear[i]) begin
          sticky_r <= 1'b0;
        end
        if (bus.clear[i]) begin
          cnt <= CNT_W'(qual);
        end else if (qual && (cnt != '1)) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign level_v[i]                 = filt;
    assign edge_v[i]                  = edge_r;
    assign sticky_v[i]                = sticky_r;
    assign count_v[i*CNT_W +: CNT_W]  = cnt;
  end

  assign bus.level_out  = level_v;
  assign bus.edge_out   = edge_v;
  assign bus.sticky_out = sticky_v;
  assign bus.edge_count = count_v;
  assign bus.irq        = |sticky_v;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised and directed bench for multi_edge_detector against a sample-history reference model.
module tb_multi_edge_detector;
  localparam int N_CH        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
  localparam int CNT_W       = 8;
  localparam int SAT_W       = 2;
  localparam int MW          = 2 * N_CH;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned SAT_MAX = (1 << SAT_W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N_CH-1:0] signal_in = '0;
  logic [N_CH-1:0] clear     = '0;
  logic [MW-1:0]   mode      = '0;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  multi_edge_detector_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus_main ();
  multi_edge_detector_if #(.N_CH(N_CH), .CNT_W(SAT_W)) bus_sat ();

  assign bus_main.signal_in = signal_in;
  assign bus_main.mode      = mode;
  assign bus_main.clear     = clear;
  assign bus_sat.signal_in  = signal_in;
  assign bus_sat.mode       = mode;
  assign bus_sat.clear      = clear;

  multi_edge_detector #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus_main.slave)
  );

  multi_edge_detector #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .CNT_W(SAT_W)
  ) u_sat (
    .clk(clk), .rst(rst), .bus(bus_sat.slave)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Filtered level follows the synchronised input once the last FILTER_LEN samples all
  // disagree with it; counts are kept unbounded and saturated only when compared.
  logic [N_CH-1:0] raw_hist[$];
  logic [N_CH-1:0] samp_hist[$];
  logic [N_CH-1:0] exp_q[$];
  logic [N_CH-1:0] m_filt;
  logic [N_CH-1:0] m_sticky;
  int unsigned     m_cnt[N_CH];

  task automatic model_reset();
    raw_hist.delete();
    samp_hist.delete();
    exp_q.delete();
    for (int k = 0; k < SYNC_STAGES; k++) raw_hist.push_back('0);
    for (int k = 0; k < FILTER_LEN; k++) samp_hist.push_back('0);
    m_filt   = '0;
    m_sticky = '0;
    for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] sq;
    logic [N_CH-1:0] qual;
    bit settled;
    sq = raw_hist.pop_front();
    raw_hist.push_back(signal_in);
    void'(samp_hist.pop_front());
    samp_hist.push_back(sq);
    qual = '0;
    for (int c = 0; c < N_CH; c++) begin
      settled = 1'b1;
      foreach (samp_hist[k]) if (samp_hist[k][c] == m_filt[c]) settled = 1'b0;
      if (settled) begin
        m_filt[c] = ~m_filt[c];
        qual[c]   = m_filt[c] ? mode[2*c] : mode[2*c+1];
      end
      if (clear[c]) m_cnt[c] = qual[c] ? 1 : 0;
      else if (qual[c]) m_cnt[c]++;
      if (qual[c]) m_sticky[c] = 1'b1;
      else if (clear[c]) m_sticky[c] = 1'b0;
    end
    exp_q.push_back(qual);
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  initial begin : scoreboard
    logic [N_CH-1:0]       exp_e;
    logic [N_CH*CNT_W-1:0] exp_c;
    logic [N_CH*SAT_W-1:0] exp_s;
    forever begin
      @(negedge clk);
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      for (int c = 0; c < N_CH; c++) begin
        exp_c[c*CNT_W +: CNT_W] = (m_cnt[c] > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(m_cnt[c]);
        exp_s[c*SAT_W +: SAT_W] = (m_cnt[c] > SAT_MAX) ? SAT_W'(SAT_MAX) : SAT_W'(m_cnt[c]);
      end
      check("level",     64'(bus_main.level_out),  64'(m_filt));
      check("edge",      64'(bus_main.edge_out),   64'(exp_e));
      check("sticky",    64'(bus_main.sticky_out), 64'(m_sticky));
      check("count",     64'(bus_main.edge_count), 64'(exp_c));
      check("irq",       64'(bus_main.irq),        64'(|m_sticky));
      check("sat_count", 64'(bus_sat.edge_count),  64'(exp_s));
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : driver
    #1 rst = 1'b0;
    signal_in = '1;
    mode      = 8'h55;
    cycles(4);
    check("rst_level",  64'(bus_main.level_out),  64'h0);
    check("rst_edge",   64'(bus_main.edge_out),   64'h0);
    check("rst_sticky", 64'(bus_main.sticky_out), 64'h0);
    check("rst_count",  64'(bus_main.edge_count), 64'h0);
    check("rst_irq",    64'(bus_main.irq),        64'h0);
    rst = 1'b1;
    cycles(12);
    check("por_count",  64'(bus_main.edge_count), 64'h01010101);
    check("por_level",  64'(bus_main.level_out),  64'hF);
    check("por_irq",    64'(bus_main.irq),        64'h1);

    // glitch rejection on ch0
    signal_in = '0;
    cycles(10);
    clear = '1; cycles(1); clear = '0;
    cycles(2);
    signal_in[0] = 1'b1; cycles(3); signal_in[0] = 1'b0;
    cycles(10);
    check("glitch3_level", 64'(bus_main.level_out),  64'h0);
    check("glitch3_count", 64'(bus_main.edge_count), 64'h0);
    signal_in[0] = 1'b1; cycles(4); signal_in[0] = 1'b0;
    cycles(12);
    check("glitch4_count", 64'(bus_main.edge_count), 64'h1);

    // modes off/rise/fall/both
    clear = '1; cycles(1); clear = '0;
    mode = 8'hE4;
    signal_in = '1; cycles(8);
    signal_in = '0; cycles(12);
    check("mode_count", 64'(bus_main.edge_count), 64'h02010100);

    // clear coinciding with a qualified edge on ch1
    clear = '1; cycles(1); clear = '0;
    mode = 8'h55;
    cycles(2);
    signal_in[1] = 1'b1;
    cycles(5);
    clear[1] = 1'b1; cycles(1); clear[1] = 1'b0;
    cycles(2);
    check("race_sticky", 64'(bus_main.sticky_out), 64'h2);
    check("race_count",  64'(bus_main.edge_count), 64'h00000100);
    clear[1] = 1'b1; cycles(1); clear[1] = 1'b0;
    cycles(1);
    check("clr_sticky", 64'(bus_main.sticky_out), 64'h0);
    check("clr_count",  64'(bus_main.edge_count), 64'h0);
    check("clr_irq",    64'(bus_main.irq),        64'h0);
    signal_in = '0;
    cycles(10);

    // saturation on ch2
    clear = '1; cycles(1); clear = '0;
    repeat (5) begin
      signal_in[2] = 1'b1; cycles(6);
      signal_in[2] = 1'b0; cycles(6);
    end
    cycles(4);
    check("sat_ch2",    64'(bus_sat.edge_count[5:4]),    64'h3);
    check("main_ch2",   64'(bus_main.edge_count[23:16]), 64'h5);
    check("sat_sticky", 64'(bus_sat.sticky_out[2]),      64'h1);

    // reset in the middle of a filter count
    signal_in[0] = 1'b1;
    cycles(4);
    #2 rst = 1'b0;
    #1;
    check("mid_level",  64'(bus_main.level_out),  64'h0);
    check("mid_sticky", 64'(bus_main.sticky_out), 64'h0);
    check("mid_count",  64'(bus_main.edge_count), 64'h0);
    check("mid_irq",    64'(bus_main.irq),        64'h0);
    check("mid_sat",    64'(bus_sat.edge_count),  64'h0);
    cycles(2);
    rst = 1'b1;
    cycles(12);
    check("fresh_count", 64'(bus_main.edge_count), 64'h1);
    check("fresh_level", 64'(bus_main.level_out),  64'h1);

    // random traffic
    repeat (3000) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 5) == 0) signal_in[c] = ~signal_in[c];
        clear[c] = ($urandom_range(0, 29) == 0);
      end
      if ($urandom_range(0, 49) == 0) mode = MW'($urandom);
      cycles(1);
    end
    clear = '0;
    cycles(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
